// File: rtl/fsm_mon_pkg.sv
// Shared constants for the FSM assertion monitor: probe bus layout,
// cfg_data field offsets, window limits and a first-set encoder.
package fsm_mon_pkg;

  localparam int BUS_W       = 7;
  localparam int PROBE_W     = 2 * BUS_W;
  localparam int SEL_W       = 4;
  localparam int PROBE_PAD_W = 2 ** SEL_W;
  localparam int IDX_W       = 5;
  localparam int WIN_W_DEF   = 7;
  localparam int MAX_HI      = 2 ** WIN_W_DEF - 1;

  // cfg_data = {en, a_sel, a_rise, b_sel, b_rise, lo, hi}
  function automatic int lo_lsb(int w);
    return w;
  endfunction

  function automatic int br_bit(int w);
    return 2 * w;
  endfunction

  function automatic int bs_lsb(int w);
    return 2 * w + 1;
  endfunction

  function automatic int ar_bit(int w);
    return 2 * w + SEL_W + 1;
  endfunction

  function automatic int as_lsb(int w);
    return 2 * w + SEL_W + 2;
  endfunction

  function automatic int en_bit(int w);
    return 2 * w + 2 * SEL_W + 2;
  endfunction

  function automatic int cfg_w(int w);
    return 2 * w + 2 * SEL_W + 3;
  endfunction

  // Lowest set bit index; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] first_set(
    input logic [31:0] v
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fsm_assert_monitor_if.sv
// Observed FSM buses plus rule-programming port of the monitor.
// master: bench/driver side, slave: monitor side.
interface fsm_assert_monitor_if
  import fsm_mon_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) ();

  logic [BUS_W-1:0]        dut_in;
  logic [BUS_W-1:0]        dut_out;
  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [cfg_w(WIN_W)-1:0] cfg_data;

  modport master (
    output dut_in, dut_out,
    output cfg_we, cfg_idx, cfg_data
  );

  modport slave (
    input dut_in, dut_out,
    input cfg_we, cfg_idx, cfg_data
  );

endinterface

// File: rtl/assert_rule_checker.sv
// One rule slot: rose/fell(A) |-> ##[lo:hi] rose/fell(B).
// Ports: edge vectors in, slot write strobe/data in, fail pulse/cfg_err out.
module assert_rule_checker
  import fsm_mon_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PROBE_PAD_W-1:0]  rise_i,
  input  logic [PROBE_PAD_W-1:0]  fall_i,
  input  logic                    cfg_we_i,
  input  logic [cfg_w(WIN_W)-1:0] cfg_data_i,
  output logic                    fail_o,
  output logic                    cfg_err_o
);

  localparam int HMAX = 2 ** WIN_W - 1;
  localparam int CW   = cfg_w(WIN_W);

  logic [CW-1:0]    cfg_q, cfg_d;
  logic             err_q, err_d;
  logic [HMAX-1:0]  pend_q, pend_d;
  logic             fail_q, fail_d;
  logic [HMAX:0]    cand;

  logic             en, a_rise, b_rise;
  logic [SEL_W-1:0] a_sel, b_sel;
  logic [WIN_W-1:0] lo, hi;
  logic [WIN_W-1:0] w_lo, w_hi;
  logic             w_bad;
  logic             a_evt, b_evt;

  assign en     = cfg_q[en_bit(WIN_W)];
  assign a_sel  = cfg_q[as_lsb(WIN_W) +: SEL_W];
  assign a_rise = cfg_q[ar_bit(WIN_W)];
  assign b_sel  = cfg_q[bs_lsb(WIN_W) +: SEL_W];
  assign b_rise = cfg_q[br_bit(WIN_W)];
  assign lo     = cfg_q[lo_lsb(WIN_W) +: WIN_W];
  assign hi     = cfg_q[0 +: WIN_W];

  assign w_lo  = cfg_data_i[lo_lsb(WIN_W) +: WIN_W];
  assign w_hi  = cfg_data_i[0 +: WIN_W];
  assign w_bad = w_lo > w_hi;

  assign a_evt = en &
    (a_rise ? rise_i[a_sel] : fall_i[a_sel]);
  assign b_evt = en &
    (b_rise ? rise_i[b_sel] : fall_i[b_sel]);

  // An inverted window is stored but kept disabled.
  always_comb begin
    cfg_d = cfg_q;
    err_d = err_q;
    if (cfg_we_i) begin
      cfg_d = cfg_data_i;
      err_d = w_bad;
      if (w_bad) cfg_d[en_bit(WIN_W)] = 1'b0;
    end
  end

  // cand[k] = live attempt of age k this cycle.
  always_comb begin
    cand   = {pend_q, a_evt};
    pend_d = '0;
    fail_d = 1'b0;
    for (int k = 0; k <= HMAX; k++) begin
      if (b_evt && k >= int'(lo) && k <= int'(hi))
        cand[k] = 1'b0;
    end
    fail_d = cand[hi];
    for (int k = 0; k < HMAX; k++) begin
      if (k < int'(hi)) pend_d[k] = cand[k];
    end
    if (!en || cfg_we_i) begin
      pend_d = '0;
      fail_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      err_q  <= 1'b0;
      pend_q <= '0;
      fail_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      fail_q <= fail_d;
    end
  end

  assign fail_o    = fail_q;
  assign cfg_err_o = err_q;

endmodule

// File: rtl/fsm_assert_monitor.sv
// Runtime-programmable temporal rule checker over FSM in/out buses.
// Ports: clk, rst_n, bus (probe + cfg), fail/fail_sticky/first_*/cfg_err.
module fsm_assert_monitor
  import fsm_mon_pkg::*;
#(
  parameter int NUM_RULES = 20,
  parameter int WIN_W     = WIN_W_DEF,
  parameter int TS_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fsm_assert_monitor_if.slave  bus,
  output logic [NUM_RULES-1:0] fail,
  output logic                 fail_sticky,
  output logic [IDX_W-1:0]     first_rule,
  output logic [TS_W-1:0]      first_ts,
  output logic [NUM_RULES-1:0] cfg_err
);

  localparam int PAD = PROBE_PAD_W - PROBE_W;

  logic [PROBE_W-1:0]     p, p_q;
  logic                   hist_q;
  logic [TS_W-1:0]        ts_q;
  logic                   sticky_q;
  logic [IDX_W-1:0]       frule_q;
  logic [TS_W-1:0]        fts_q;
  logic [PROBE_PAD_W-1:0] rise, fall;

  assign p = {bus.dut_out, bus.dut_in};

  // Selects 14/15 read the zero pad and never fire.
  assign rise = hist_q ?
    {{PAD{1'b0}}, p & ~p_q} : '0;
  assign fall = hist_q ?
    {{PAD{1'b0}}, ~p & p_q} : '0;

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
    assert_rule_checker #(
      .WIN_W(WIN_W)
    ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .rise_i     (rise),
      .fall_i     (fall),
      .cfg_we_i   (bus.cfg_we &&
                   bus.cfg_idx == IDX_W'(r)),
      .cfg_data_i (bus.cfg_data),
      .fail_o     (fail[r]),
      .cfg_err_o  (cfg_err[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q      <= '0;
      hist_q   <= 1'b0;
      ts_q     <= '0;
      sticky_q <= 1'b0;
      frule_q  <= '0;
      fts_q    <= '0;
    end else begin
      p_q    <= p;
      hist_q <= 1'b1;
      ts_q   <= ts_q + 1'b1;
      if (|fail && !sticky_q) begin
        sticky_q <= 1'b1;
        frule_q  <= first_set(32'(fail));
        fts_q    <= ts_q;
      end
    end
  end

  assign fail_sticky = sticky_q;
  assign first_rule  = frule_q;
  assign first_ts    = fts_q;

endmodule

// File: tb/tb_fsm_assert_monitor.sv
// Scoreboard bench for fsm_assert_monitor: directed scenarios push
// expected fail pulses and state values; a monitor pops and compares.
module tb_fsm_assert_monitor;
  import fsm_mon_pkg::*;

  localparam int NR  = 20;
  localparam int TSW = 16;
  localparam int K_FAIL = 0;
  localparam int K_STK  = 1;
  localparam int K_FR   = 2;
  localparam int K_FTS  = 3;
  localparam int K_ERR  = 4;
  localparam logic [6:0] IN_INIT  = 7'b0100011;
  localparam logic [6:0] OUT_INIT = 7'b0000100;

  typedef struct {
    int          ts;
    logic [31:0] vec;
  } fexp_t;

  typedef struct {
    int          ts;
    int          kind;
    logic [31:0] val;
    string       nm;
  } cexp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  fail_w;
  logic           stk_w;
  logic [4:0]     fr_w;
  logic [TSW-1:0] fts_w;
  logic [NR-1:0]  err_w;

  fexp_t fq[$];
  cexp_t cq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  fsm_assert_monitor_if #(.WIN_W(7)) ifc ();

  fsm_assert_monitor #(
    .NUM_RULES(NR),
    .WIN_W(7),
    .TS_W(TSW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .fail        (fail_w),
    .fail_sticky (stk_w),
    .first_rule  (fr_w),
    .first_ts    (fts_w),
    .cfg_err     (err_w)
  );

  always #5 clk = ~clk;

  // Reference timestamp: equals the monitor's cycle count.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic logic [31:0] pick(int k);
    case (k)
      K_FAIL:  return 32'(fail_w);
      K_STK:   return 32'(stk_w);
      K_FR:    return 32'(fr_w);
      K_FTS:   return 32'(fts_w);
      default: return 32'(err_w);
    endcase
  endfunction

  always @(negedge clk) begin : mon
    logic [31:0] act;
    if (rst_n) begin
      while (fq.size() > 0 && fq[0].ts < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_fail ts=%0d got 0 want %0h",
                 fq[0].ts, fq[0].vec);
        void'(fq.pop_front());
      end
      if (fail_w != '0) begin
        checks++;
        if (fq.size() > 0 && fq[0].ts == cyc) begin
          if (32'(fail_w) !== fq[0].vec) begin
            errors++;
            $display("FAIL fail_vec ts=%0d got %0h want %0h",
                     cyc, fail_w, fq[0].vec);
          end
          void'(fq.pop_front());
        end else begin
          errors++;
          $display("FAIL unexpected_fail ts=%0d got %0h want 0",
                   cyc, fail_w);
        end
      end
      for (int i = cq.size() - 1; i >= 0; i--) begin
        if (cq[i].ts <= cyc) begin
          act = pick(cq[i].kind);
          checks++;
          if (cq[i].ts != cyc || act !== cq[i].val) begin
            errors++;
            $display("FAIL %s ts=%0d got %0h want %0h",
                     cq[i].nm, cyc, act, cq[i].val);
          end
          cq.delete(i);
        end
      end
    end
  end

  task automatic expf(int t, logic [31:0] v);
    fexp_t e;
    e.ts = t;
    e.vec = v;
    fq.push_back(e);
  endtask

  task automatic expc(int t, int k, logic [31:0] v, string nm);
    cexp_t e;
    e.ts = t;
    e.kind = k;
    e.val = v;
    e.nm = nm;
    cq.push_back(e);
  endtask

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.dut_in = IN_INIT;
    ifc.dut_out = OUT_INIT;
    ifc.cfg_we = 1'b0;
    ifc.cfg_idx = '0;
    ifc.cfg_data = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cfg(int idx, bit en, int as, bit ar,
                     int bs, bit br, int lo, int hi);
    ifc.cfg_we = 1'b1;
    ifc.cfg_idx = 5'(idx);
    ifc.cfg_data = {en, 4'(as), ar, 4'(bs), br,
                    7'(lo), 7'(hi)};
    @(posedge clk);
    #1;
    ifc.cfg_we = 1'b0;
  endtask

  task automatic exp_reset_state(string tag);
    expc(0, K_FAIL, 0, {tag, "_fail"});
    expc(0, K_STK, 0, {tag, "_sticky"});
    expc(0, K_FR, 0, {tag, "_first_rule"});
    expc(0, K_FTS, 0, {tag, "_first_ts"});
    expc(0, K_ERR, 0, {tag, "_cfg_err"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: fell(in0) -> ##[6:51] fell(out2), satisfied at 20
    do_reset();
    exp_reset_state("rst");
    cfg(0, 1, 0, 0, 9, 0, 6, 51);
    cfg(25, 1, 0, 0, 9, 0, 9, 3);
    expc(3, K_ERR, 0, "idx_oob_ignored");
    goto(10);
    ifc.dut_in[0] = 1'b0;
    goto(20);
    ifc.dut_out[2] = 1'b0;
    expc(70, K_STK, 0, "t1_sticky");
    goto(75);

    // 2: no B -> fail at 62; rule 7 twin, rule 4 later at 71
    do_reset();
    expf(62, 32'h81);
    expf(71, 32'h10);
    cfg(0, 1, 0, 0, 9, 0, 6, 51);
    cfg(7, 1, 0, 0, 9, 0, 6, 51);
    cfg(4, 1, 0, 0, 10, 1, 0, 60);
    expc(62, K_STK, 0, "t2_sticky_lag");
    expc(63, K_STK, 1, "t2_sticky");
    expc(63, K_FR, 0, "t2_first_rule");
    expc(63, K_FTS, 62, "t2_first_ts");
    expc(73, K_FR, 0, "t2_rule_frozen");
    expc(73, K_FTS, 62, "t2_ts_frozen");
    goto(10);
    ifc.dut_in[0] = 1'b0;
    goto(75);

    // 3: lo=0 hi=4 fell(in5) -> rose(out1)
    do_reset();
    cfg(3, 1, 5, 0, 8, 1, 0, 4);
    goto(10);
    ifc.dut_in[5] = 1'b0;
    ifc.dut_out[1] = 1'b1;
    goto(20);
    ifc.dut_in[5] = 1'b1;
    ifc.dut_out[1] = 1'b0;
    expf(35, 32'h8);
    expc(36, K_FR, 3, "t3_first_rule");
    expc(36, K_FTS, 35, "t3_first_ts");
    expc(60, K_FTS, 35, "t3_ts_hold");
    goto(30);
    ifc.dut_in[5] = 1'b0;
    goto(35);
    ifc.dut_out[1] = 1'b1;
    goto(40);
    ifc.dut_in[5] = 1'b1;
    ifc.dut_out[1] = 1'b0;
    goto(50);
    ifc.dut_in[5] = 1'b0;
    goto(54);
    ifc.dut_out[1] = 1'b1;
    goto(62);

    // 4: overlapping attempts, one B; then B before lo
    do_reset();
    cfg(1, 1, 0, 0, 9, 0, 6, 51);
    cfg(8, 0, 0, 0, 9, 0, 6, 51);
    cfg(2, 1, 14, 0, 9, 0, 0, 3);
    expf(112, 32'h2);
    goto(10);
    ifc.dut_in[0] = 1'b0;
    goto(20);
    ifc.dut_in[0] = 1'b1;
    goto(30);
    ifc.dut_in[0] = 1'b0;
    goto(40);
    ifc.dut_out[2] = 1'b0;
    goto(50);
    ifc.dut_in[0] = 1'b1;
    goto(55);
    ifc.dut_out[2] = 1'b1;
    goto(60);
    ifc.dut_in[0] = 1'b0;
    goto(65);
    ifc.dut_out[2] = 1'b0;
    expc(113, K_FR, 1, "t4_first_rule");
    goto(115);

    // 5: inverted window held off, valid rewrite re-arms
    do_reset();
    expc(1, K_ERR, 32'h20, "t5_cfg_err_set");
    cfg(5, 1, 0, 0, 9, 0, 9, 3);
    goto(10);
    ifc.dut_in[0] = 1'b0;
    goto(20);
    expc(21, K_ERR, 0, "t5_cfg_err_clr");
    expc(21, K_STK, 0, "t5_no_fail");
    cfg(5, 1, 1, 0, 13, 1, 0, 10);
    expf(41, 32'h20);
    expc(42, K_FR, 5, "t5_first_rule");
    expc(42, K_FTS, 41, "t5_first_ts");
    goto(30);
    ifc.dut_in[1] = 1'b0;
    goto(45);

    // 6: reset mid-window drops the live attempt
    do_reset();
    cfg(0, 1, 0, 0, 9, 0, 6, 51);
    cfg(3, 1, 5, 0, 8, 1, 0, 2);
    expf(13, 32'h8);
    expc(14, K_STK, 1, "t6_sticky");
    expc(14, K_FR, 3, "t6_first_rule");
    expc(14, K_FTS, 13, "t6_first_ts");
    goto(10);
    ifc.dut_in[0] = 1'b0;
    ifc.dut_in[5] = 1'b0;
    goto(30);
    do_reset();
    exp_reset_state("t6_rst");
    goto(80);

    checks++;
    if (fq.size() + cq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0",
               fq.size() + cq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
